// File: rtl/nonce_hub_pkg.sv
// nonce_hub_pkg: nonce width, one-hot TX state encoding and the
// round-robin index helper shared by the nonce hub files.
package nonce_hub_pkg;

    localparam int NONCE_W = 32;

    typedef enum logic [3:0] {
        TX_IDLE      = 4'b0001,
        TX_SEND      = 4'b0010,
        TX_WAIT_BUSY = 4'b0100,
        TX_WAIT_IDLE = 4'b1000
    } tx_state_t;

    function automatic int unsigned rr_next(input int unsigned idx,
                                            input int unsigned n);
        return (idx >= n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/nonce_fifo.sv
// nonce_fifo: single-clock circular FIFO with occupancy count.
// A push while full is accepted only alongside a pop.
module nonce_fifo
    import nonce_hub_pkg::*;
#(
    parameter int W    = NONCE_W,
    parameter int LOG2 = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic [W-1:0]  din,
    input  logic          pop,
    output logic [W-1:0]  dout,
    output logic          full,
    output logic          empty,
    output logic [LOG2:0] count
);
    localparam int DEPTH = 1 << LOG2;

    logic [W-1:0]    mem [DEPTH];
    logic [LOG2-1:0] wr_ptr;
    logic [LOG2-1:0] rd_ptr;
    logic            do_push;
    logic            do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (LOG2+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + (LOG2+1)'(do_push) - (LOG2+1)'(do_pop);
        end
    end

endmodule

// File: rtl/nonce_hub.sv
// nonce_hub: per-channel ticket edge detect, round-robin arbiter into a
// FIFO, and serial TX handshake. NONCE_HUB_DEDUP_EN drops repeated nonces.
module nonce_hub
    import nonce_hub_pkg::*;
#(
    parameter int SLAVES    = 2,
    parameter int FIFO_LOG2 = 3
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [SLAVES*NONCE_W-1:0] slave_nonces,
    input  logic [SLAVES-1:0]         new_nonces,
    output logic [NONCE_W-1:0]        tx_word,
    output logic                      tx_send,
    input  logic                      tx_busy,
    output logic [FIFO_LOG2:0]        fifo_count,
    output logic                      dropped,
    output logic                      found
);
    localparam int PW = (SLAVES > 1) ? $clog2(SLAVES) : 1;

    logic [SLAVES-1:0]  prev;
    logic [SLAVES-1:0]  pending;
    logic [SLAVES-1:0]  rise;
    logic [NONCE_W-1:0] hold [SLAVES];
    logic [PW-1:0]      rr_ptr;
    logic [PW-1:0]      gnt_idx;
    logic [PW-1:0]      cand;
    int unsigned        scan;
    logic               gnt_vld;
    logic               dup;
    logic               push;
    logic               pop;
    logic               fifo_full;
    logic               fifo_empty;
    logic [NONCE_W-1:0] gnt_word;
    logic [NONCE_W-1:0] fifo_dout;
    tx_state_t          state_q;
    tx_state_t          state_d;

    assign rise = new_nonces & ~prev;

    // Scan starts one past the last grant so every channel gets a turn.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = rr_ptr;
        cand    = rr_ptr;
        scan    = 32'(rr_ptr);
        for (int j = 0; j < SLAVES; j++) begin
            scan = rr_next(scan, SLAVES);
            cand = PW'(scan);
            if (!gnt_vld && pending[cand]) begin
                gnt_vld = 1'b1;
                gnt_idx = cand;
            end
        end
        if (fifo_full && !pop) gnt_vld = 1'b0;
    end

    assign gnt_word = hold[gnt_idx];
    assign push     = gnt_vld && !dup;
    assign found    = push;

`ifdef NONCE_HUB_DEDUP_EN
    logic [NONCE_W-1:0] last_word;
    logic               last_vld;

    assign dup = last_vld && (last_word == gnt_word);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_word <= '0;
            last_vld  <= 1'b0;
        end else if (push) begin
            last_word <= gnt_word;
            last_vld  <= 1'b1;
        end
    end
`else
    assign dup = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev    <= '0;
            pending <= '0;
            dropped <= 1'b0;
            rr_ptr  <= PW'(SLAVES - 1);
            for (int i = 0; i < SLAVES; i++) hold[i] <= '0;
        end else begin
            prev <= new_nonces;
            if (gnt_vld) begin
                pending[gnt_idx] <= 1'b0;
                rr_ptr           <= gnt_idx;
            end
            // A channel emptied by this cycle's grant may capture again.
            for (int i = 0; i < SLAVES; i++) begin
                if (rise[i]) begin
                    if (!pending[i] || (gnt_vld && gnt_idx == PW'(i))) begin
                        pending[i] <= 1'b1;
                        hold[i]    <= slave_nonces[i*NONCE_W +: NONCE_W];
                    end else begin
                        dropped <= 1'b1;
                    end
                end
            end
        end
    end

    nonce_fifo #(
        .W    (NONCE_W),
        .LOG2 (FIFO_LOG2)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .din   (gnt_word),
        .pop   (pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= TX_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (1'b1)
            state_q[0]: if (!fifo_empty && !tx_busy) state_d = TX_SEND;
            state_q[1]: state_d = TX_WAIT_BUSY;
            state_q[2]: if (tx_busy) state_d = TX_WAIT_IDLE;
            state_q[3]: if (!tx_busy) state_d = TX_IDLE;
            default:    state_d = TX_IDLE;
        endcase
    end

    always_comb begin
        tx_send = 1'b0;
        pop     = 1'b0;
        unique case (1'b1)
            state_q[0]: pop = !fifo_empty && !tx_busy;
            state_q[1]: tx_send = 1'b1;
            default:    ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)    tx_word <= '0;
        else if (pop) tx_word <= fifo_dout;
    end

endmodule
